rf_read_arbiter: RTL and testbench
==================================

RF_READ_ARBITER -- requirements
Module: rf_read_arbiter

Interface
REQ-001 Parameter DATA_W, default 16; register width in bits.
REQ-002 Parameter NUM_REQ, default 4; number of read requesters (fixed power of two).
REQ-003 Parameter NUM_REGS, default 8; register count; ADDR_W = 3.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  NUM_REQ  per-requester read request.
REQ-007 req_addr  input  NUM_REQ*ADDR_W  packed read addresses; requester i at bits [i*3+2:i*3].
REQ-008 req_ready  output  NUM_REQ  one-hot grant; request i accepted when req_valid[i] && req_ready[i].
REQ-009 wr_en  input  1  register write strobe.
REQ-010 wr_addr  input  ADDR_W  write address.
REQ-011 wr_data  input  DATA_W  write data.
REQ-012 rsp_valid  output  1  response holding register occupied.
REQ-013 rsp_ready  input  1  consumer accepts response.
REQ-014 rsp_id  output  2  index of requester owning the response.
REQ-015 rsp_data  output  DATA_W  read data.

Function
REQ-016 Block SHALL own NUM_REGS x DATA_W storage and a single shared read port; at most one read is granted per cycle.
REQ-017 req_ready SHALL be combinational, at most one bit set, and zero unless (!rsp_valid || rsp_ready).
REQ-018 Arbitration SHALL be round-robin: search starts at pointer ptr, ascending modulo NUM_REQ; first valid requester wins.
REQ-019 On an accepted grant to index g, ptr SHALL become (g+1) mod NUM_REQ on the next edge; with no grant, ptr holds.
REQ-020 Read latency SHALL be 1 cycle: accepted request in cycle N gives rsp_valid=1, rsp_id=g and rsp_data=reg[addr] in cycle N+1.
REQ-021 Write bypass: wr_en with wr_addr equal to the granted address in the same cycle SHALL return wr_data, not the old value.
REQ-022 Writes SHALL commit at the edge regardless of arbitration or stall state.
REQ-023 When rsp_valid && !rsp_ready, rsp_id and rsp_data SHALL hold stable; later writes to that address SHALL NOT alter the held data.
REQ-024 When rsp_valid && rsp_ready and a new grant occurs in the same cycle, the response SHALL be replaced without a bubble (full throughput).
REQ-025 When rsp_valid && rsp_ready and no grant occurs, rsp_valid SHALL clear on the next edge.
REQ-026 rsp_data SHALL never be X after reset; storage is reset-initialised.

Reset
REQ-027 On rst_n low, immediately: all registers = 0, ptr = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0.
REQ-028 A response pending when reset asserts SHALL be discarded; no grants while rst_n is low.
REQ-029 First grant after reset release SHALL favour requester 0.

Structure
REQ-030 Package rf_pkg SHALL hold DATA_W, NUM_REGS, ADDR_W, NUM_REQ and the requester-id typedef.
REQ-031 Sub-module rr_arbiter (NUM_REQ requests, enable, one-hot grant, pointer update) SHALL implement REQ-018/019.
REQ-032 Read selection SHALL be an 8:1 data mux of the storage indexed by the granted address.

Verification
REQ-033 Reset, write reg3=0x1234, requester 1 reads addr 3 -> next cycle rsp_valid=1, rsp_id=1, rsp_data=0x1234.
REQ-034 All four requesters valid continuously, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, one response per cycle.
REQ-035 Requester 2 reads addr 5 while wr_en writes 0xBEEF to addr 5 in the same cycle -> rsp_data=0xBEEF.
REQ-036 rsp_ready=0 for 3 cycles with rsp_valid=1 -> req_ready=0, rsp_data/rsp_id stable; write to the same address is not reflected.
REQ-037 Assert rst_n low while rsp_valid=1 -> rsp_valid=0 immediately; after release all reads return 0 and requester 0 wins first.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file read arbiter.
package rf_pkg;
  localparam int DATA_W   = 16;
  localparam int NUM_REQ  = 4;
  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 3;
  localparam int ID_W     = $clog2(NUM_REQ);

  typedef logic [ID_W-1:0]   req_id_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at ptr, ptr advances past the winner.
module rr_arbiter #(
  parameter  int NUM_REQ = rf_pkg::NUM_REQ,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx;
  logic             found;

  // Index arithmetic wraps naturally because NUM_REQ is a power of two.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr + IDX_W'(k);
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= gnt_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/rf_read_arbiter.sv
// Register file with one shared read port arbitrated round-robin among requesters,
// 1-cycle read latency, write bypass and a stallable response holding register.
module rf_read_arbiter #(
  parameter int DATA_W   = rf_pkg::DATA_W,
  parameter int NUM_REQ  = rf_pkg::NUM_REQ,
  parameter int NUM_REGS = rf_pkg::NUM_REGS
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*rf_pkg::ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            wr_en,
  input  logic [rf_pkg::ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]               wr_data,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output rf_pkg::req_id_t                 rsp_id,
  output logic [DATA_W-1:0]               rsp_data
);

  localparam int ADDR_W = rf_pkg::ADDR_W;
  localparam int ID_W   = $clog2(NUM_REQ);

  logic [DATA_W-1:0]  regs [NUM_REGS];
  logic               enable;
  logic               accept;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic [ADDR_W-1:0]  gnt_addr;
  logic [DATA_W-1:0]  rd_data;

  // A grant is only possible when the holding register is free or draining this cycle.
  assign enable = rst_n && (!rsp_valid || rsp_ready);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (enable),
    .req     (req_valid),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign accept    = |gnt;
  assign gnt_addr  = req_addr[gnt_idx*ADDR_W +: ADDR_W];

  // Same-cycle write to the granted address wins over the stored value.
  always_comb begin
    rd_data = regs[gnt_addr];
    if (wr_en && (wr_addr == gnt_addr)) begin
      rd_data = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Data is captured at grant time, so later writes never disturb a stalled response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_id    <= gnt_idx;
      rsp_data  <= rd_data;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Directed bench for rf_read_arbiter with a response scoreboard queue.
module tb_rf_read_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [11:0] req_addr = '0;
  logic [3:0]  req_ready;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] data;
  } rsp_t;

  rsp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  logic held_valid = 1'b0;

  rf_read_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  function automatic logic [11:0] pack_addr(input logic [2:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [11:0] a, input logic we,
                               input logic [2:0] wa, input logic [15:0] wd, input logic rr);
    req_valid = v;
    req_addr  = a;
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    rsp_ready = rr;
  endtask

  task automatic expectGrant(input string tag, input logic [1:0] g, input logic [15:0] d);
    rsp_t e;
    logic [3:0] onehot;
    #1;
    onehot = 4'b0001 << g;
    chk({tag, ".ready"}, 32'(req_ready), 32'(onehot));
    e.id   = g;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic expectNoGrant(input string tag);
    #1;
    chk({tag, ".ready"}, 32'(req_ready), 32'(0));
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, ".valid"}, 32'(rsp_valid), 32'(sb.size() > 0));
    if (sb.size() > 0) begin
      chk({tag, ".id"}, 32'(rsp_id), 32'(sb[0].id));
      chk({tag, ".data"}, 32'(rsp_data), 32'(sb[0].data));
    end
  endtask

  task automatic tick(input string tag);
    logic consumed;
    consumed = rsp_ready && held_valid;
    @(posedge clk);
    #1;
    if (consumed) void'(sb.pop_front());
    held_valid = sb.size() > 0;
    checkOutput(tag);
  endtask

  initial begin
    logic [11:0] all_addr;
    all_addr = pack_addr(3'd3, 3'd5, 3'd3, 3'd5);

    // Asynchronous reset with every requester asking: nothing may be granted.
    #1;
    rst_n = 1'b0;
    applyStimulus(4'hF, all_addr, 1'b0, 3'd0, 16'h0, 1'b0);
    #2;
    chk("reset.valid", 32'(rsp_valid), 32'(0));
    chk("reset.id", 32'(rsp_id), 32'(0));
    chk("reset.data", 32'(rsp_data), 32'(0));
    chk("reset.ready", 32'(req_ready), 32'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Write reg3, then requester 1 reads it.
    applyStimulus(4'h0, 12'h0, 1'b1, 3'd3, 16'h1234, 1'b0);
    tick("write3");
    applyStimulus(4'b0010, pack_addr(3'd0, 3'd3, 3'd0, 3'd0), 1'b0, 3'd0, 16'h0, 1'b1);
    expectGrant("read3", 2'd1, 16'h1234);
    tick("read3");
    applyStimulus(4'h0, 12'h0, 1'b0, 3'd0, 16'h0, 1'b1);
    expectNoGrant("drain");
    tick("drain");

    // Write bypass: requester 2 reads addr 5 while it is being written.
    applyStimulus(4'b0100, pack_addr(3'd0, 3'd0, 3'd5, 3'd0), 1'b1, 3'd5, 16'hBEEF, 1'b0);
    expectGrant("bypass", 2'd2, 16'hBEEF);
    tick("bypass");

    // Pointer sits at 3; requester 0 wins after wrap, replacing the response without a bubble.
    applyStimulus(4'b0001, pack_addr(3'd3, 3'd0, 3'd0, 3'd0), 1'b0, 3'd0, 16'h0, 1'b1);
    expectGrant("wrap", 2'd0, 16'h1234);
    tick("wrap");

    // Three stall cycles; a write to the held address must not leak into the response.
    applyStimulus(4'hF, all_addr, 1'b1, 3'd3, 16'h5555, 1'b0);
    expectNoGrant("stall0");
    tick("stall0");
    applyStimulus(4'hF, all_addr, 1'b0, 3'd0, 16'h0, 1'b0);
    expectNoGrant("stall1");
    tick("stall1");
    expectNoGrant("stall2");
    tick("stall2");

    // Release the stall: pointer held at 1 during the stall.
    applyStimulus(4'hF, all_addr, 1'b0, 3'd0, 16'h0, 1'b1);
    expectGrant("unstall1", 2'd1, 16'hBEEF);
    tick("unstall1");
    expectGrant("unstall2", 2'd2, 16'h5555);
    tick("unstall2");

    // Reset while a response is held: it vanishes at once and nothing is granted.
    applyStimulus(4'hF, all_addr, 1'b0, 3'd0, 16'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rstmid.valid", 32'(rsp_valid), 32'(0));
    chk("rstmid.data", 32'(rsp_data), 32'(0));
    chk("rstmid.ready", 32'(req_ready), 32'(0));
    sb.delete();
    held_valid = 1'b0;
    tick("rstmid.hold");
    rst_n = 1'b1;

    // Continuous requests at full throughput: 0,1,2,3,0 with cleared storage.
    applyStimulus(4'hF, all_addr, 1'b0, 3'd0, 16'h0, 1'b1);
    expectGrant("rr0", 2'd0, 16'h0);
    tick("rr0");
    expectGrant("rr1", 2'd1, 16'h0);
    tick("rr1");
    expectGrant("rr2", 2'd2, 16'h0);
    tick("rr2");
    expectGrant("rr3", 2'd3, 16'h0);
    tick("rr3");
    expectGrant("rr4", 2'd0, 16'h0);
    tick("rr4");

    applyStimulus(4'h0, 12'h0, 1'b0, 3'd0, 16'h0, 1'b1);
    expectNoGrant("idle");
    tick("idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
